// File: rtl/systolic_matmul_engine.sv
// Bus-slave matrix-multiply engine: C = A(ROWS x K) * B(K x COLS) on an
// output-stationary signed MAC array fed from on-chip operand buffers.
module systolic_matmul_engine #(
  parameter int          ROWS             = 4,
  parameter int          COLS             = 4,
  parameter int          DATA_WIDTH       = 16,
  parameter int          ACC_WIDTH        = 32,
  parameter int          MAX_K            = 16,
  parameter int          BUS_PACKET_WIDTH = 256,
  parameter logic [31:0] BASE_ADDR        = 32'h0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BUS_PACKET_WIDTH-1:0] bus_slave_input,
  input  logic [31:0]                 bus_slave_addr,
  input  logic                        bus_slave_read_request,
  input  logic                        bus_slave_write_request,
  output logic                        bus_slave_request_finish,
  output logic [BUS_PACKET_WIDTH-1:0] bus_slave_output,
  output logic                        busy,
  output logic                        done
);

  localparam int T_W  = 16;
  localparam int KI_W = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int RI_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {S_IDLE, S_COMPUTE} state_t;
  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] a_buf [MAX_K][ROWS];
  logic signed [DATA_WIDTH-1:0] b_buf [MAX_K][COLS];
  logic signed [DATA_WIDTH-1:0] a_in  [ROWS];
  logic signed [DATA_WIDTH-1:0] b_in  [COLS];
  logic signed [DATA_WIDTH-1:0] a_w   [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] b_n   [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] a_p1  [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] b_p1  [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  acc   [ROWS][COLS];

  logic [7:0]     k_reg;
  logic [T_W-1:0] t;
  logic           error;
  logic           last_step;

  logic [31:0] off;
  logic [7:0]  idx;
  logic        in_win, ctrl_hit, status_hit, a_hit, b_hit, c_hit;
  logic        svc, wr_op, rd_op, k_ok, start_ok;
  logic [BUS_PACKET_WIDTH-1:0] rdata;
  logic [KI_W-1:0] bi;
  logic [RI_W-1:0] ri;
  logic        unused_bits;

  function automatic logic signed [ACC_WIDTH-1:0] mul_ext(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] y
  );
    logic signed [2*DATA_WIDTH-1:0] p;
    p = (2*DATA_WIDTH)'(x) * (2*DATA_WIDTH)'(y);
    return ACC_WIDTH'(p);
  endfunction

  assign unused_bits = ^bus_slave_input;

  assign off        = bus_slave_addr - BASE_ADDR;
  assign in_win     = (off[31:12] == 20'd0) && (off[1:0] == 2'b00);
  assign idx        = {2'b00, off[7:2]};
  assign bi         = idx[KI_W-1:0];
  assign ri         = idx[RI_W-1:0];
  assign ctrl_hit   = in_win && (off[11:2] == 10'h000);
  assign status_hit = in_win && (off[11:2] == 10'h001);
  assign a_hit      = in_win && (off[11:8] == 4'h1) && ({24'd0, idx} < 32'(MAX_K));
  assign b_hit      = in_win && (off[11:8] == 4'h2) && ({24'd0, idx} < 32'(MAX_K));
  assign c_hit      = in_win && (off[11:8] == 4'h3) && ({24'd0, idx} < 32'(ROWS));

  // Requests are ignored during the finish cycle so a held request is served once.
  assign svc      = !bus_slave_request_finish &&
                    (bus_slave_read_request || bus_slave_write_request);
  assign wr_op    = svc && bus_slave_write_request;
  assign rd_op    = svc && !bus_slave_write_request;
  assign k_ok     = (bus_slave_input[7:0] != 8'd0) &&
                    ({24'd0, bus_slave_input[7:0]} <= 32'(MAX_K));
  assign start_ok = wr_op && (state == S_IDLE) && ctrl_hit && bus_slave_input[8] && k_ok;

  assign busy      = (state == S_COMPUTE);
  assign last_step = (t == T_W'(k_reg) + T_W'(ROWS + COLS - 2));

  // Skewed west/north feed; out-of-window steps inject zero bubbles.
  for (genvar r = 0; r < ROWS; r++) begin : g_west
    logic [T_W-1:0] dk;
    assign dk      = t - T_W'(r);
    assign a_in[r] = (t >= T_W'(r) && dk < T_W'(k_reg)) ? a_buf[dk[KI_W-1:0]][r] : '0;
  end

  for (genvar c = 0; c < COLS; c++) begin : g_north
    logic [T_W-1:0] dk;
    assign dk      = t - T_W'(c);
    assign b_in[c] = (t >= T_W'(c) && dk < T_W'(k_reg)) ? b_buf[dk[KI_W-1:0]][c] : '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c == 0) begin : g_edge_w
        assign a_w[r][c] = a_in[r];
      end else begin : g_int_w
        assign a_w[r][c] = a_p1[r][c-1];
      end
      if (r == 0) begin : g_edge_n
        assign b_n[r][c] = b_in[c];
      end else begin : g_int_n
        assign b_n[r][c] = b_p1[r-1][c];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (status_hit) begin
      rdata[15:0] = {k_reg, 5'b00000, error, done, busy};
    end else if (c_hit && !busy) begin
      for (int c = 0; c < COLS; c++) rdata[c*ACC_WIDTH +: ACC_WIDTH] = acc[ri][c];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_ok)  state_nxt = S_COMPUTE;
      S_COMPUTE: if (last_step) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_slave_request_finish <= 1'b0;
      bus_slave_output         <= '0;
      done  <= 1'b0;
      error <= 1'b0;
      k_reg <= 8'd0;
      t     <= '0;
      for (int k = 0; k < MAX_K; k++) begin
        for (int r = 0; r < ROWS; r++) a_buf[k][r] <= '0;
        for (int c = 0; c < COLS; c++) b_buf[k][c] <= '0;
      end
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          acc[r][c]  <= '0;
          a_p1[r][c] <= '0;
          b_p1[r][c] <= '0;
        end
    end else begin
      bus_slave_request_finish <= svc;
      bus_slave_output         <= rd_op ? rdata : '0;

      if (wr_op) begin
        if (busy) begin
          if (ctrl_hit || a_hit || b_hit) error <= 1'b1;
        end else begin
          if (a_hit)
            for (int r = 0; r < ROWS; r++)
              a_buf[bi][r] <= bus_slave_input[r*DATA_WIDTH +: DATA_WIDTH];
          if (b_hit)
            for (int c = 0; c < COLS; c++)
              b_buf[bi][c] <= bus_slave_input[c*DATA_WIDTH +: DATA_WIDTH];
          if (ctrl_hit && bus_slave_input[8]) begin
            if (k_ok) begin
              done  <= 1'b0;
              error <= 1'b0;
              k_reg <= bus_slave_input[7:0];
              if (!bus_slave_input[9])
                for (int r = 0; r < ROWS; r++)
                  for (int c = 0; c < COLS; c++) acc[r][c] <= '0;
            end else begin
              error <= 1'b1;
            end
          end
        end
      end

      // MAC stage: operands hop one PE east/south per step.
      if (busy) begin
        t <= t + 1'b1;
        if (last_step) done <= 1'b1;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) begin
            a_p1[r][c] <= a_w[r][c];
            b_p1[r][c] <= b_n[r][c];
            acc[r][c]  <= acc[r][c] + mul_ext(a_p1[r][c], b_p1[r][c]);
          end
      end else begin
        t <= '0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) begin
            a_p1[r][c] <= '0;
            b_p1[r][c] <= '0;
          end
      end
    end
  end

endmodule
